// File: rtl/fetch_queue.sv
// Instruction fetch queue: a circular FIFO of {instr, pc} entries fed by a combinational imem.
// Optional backpressure stall counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [63:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [63:0]                redirect_pc,
  output logic                       instr_valid,
  output logic [31:0]                instr,
  output logic [63:0]                instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH):0]     queue_count,
  output logic [31:0]                stall_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]   fetch_pc;
  logic [31:0]   q_instr [DEPTH];
  logic [63:0]   q_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          enq;

  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = q_instr[rd_ptr];
  assign instr_pc    = q_pc[rd_ptr];
  assign queue_count = count;

  // A pop frees a slot in the same edge, so a full queue can still accept a new fetch.
  assign pop = instr_valid && instr_ready;
  assign enq = !redirect_valid && ((count < CW'(DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[63:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (enq) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + 64'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= fetch_pc;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (instr_valid && !instr_ready) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule
